mac_seq: RTL and testbench

MAC_SEQ -- requirements
Module: mac_seq

---
 rtl/mac_seq.sv | 203 ++++++++++++++++++++
 tb/tb_mac_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq.sv
// mac_seq: sequences a signed 8-bit dot product over two operand vectors held
// in an external memory, driving an external registered MAC unit.
// Optional build macro MAC_SEQ_SAT_EN: clamp the captured result to signed
// 16-bit and expose a sticky 'sat' flag (cleared by the next start).
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start
// CLEAR   | clear MAC accumulator, issue read of element 0
// RUN     | issue reads 1..len-1, accumulate the previous read's data
// DRAIN   | accumulate the final element, no read
// CAPTURE | sample the MAC accumulator into the result register
// DONE    | one-cycle done pulse
module mac_seq #(
    parameter int LEN_W  = 8,
    parameter int ADDR_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [LEN_W-1:0]         len,
    input  logic [ADDR_W-1:0]        base_a,
    input  logic [ADDR_W-1:0]        base_b,
    input  logic                     abort,
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        addr_a,
    output logic [ADDR_W-1:0]        addr_b,
    input  logic signed [7:0]        a_data,
    input  logic signed [7:0]        b_data,
    output logic signed [7:0]        mac_a,
    output logic signed [7:0]        mac_b,
    output logic                     mac_en,
    output logic                     mac_clr,
    input  logic signed [25:0]       mac_acc,
    output logic                     busy,
    output logic                     done,
    output logic                     aborted,
`ifdef MAC_SEQ_SAT_EN
    output logic                     sat,
`endif
    output logic signed [25:0]       result
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        RUN     = 3'd2,
        DRAIN   = 3'd3,
        CAPTURE = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [LEN_W-1:0]        cnt_q, cnt_d;        // reads still to issue after the current one
    logic [ADDR_W-1:0]       addr_a_q, addr_a_d;
    logic [ADDR_W-1:0]       addr_b_q, addr_b_d;
    logic signed [25:0]      result_q, result_d;
    logic                    aborted_q, aborted_d;
    logic signed [25:0]      capture_val;
`ifdef MAC_SEQ_SAT_EN
    logic                    sat_q, sat_d;
    logic                    clamp_hi, clamp_lo;
`endif

    // Value loaded into result in CAPTURE (clamped when saturation is built in).
`ifdef MAC_SEQ_SAT_EN
    always_comb begin
        clamp_hi    = (mac_acc > 26'sd32767);
        clamp_lo    = (mac_acc < -26'sd32768);
        capture_val = mac_acc;
        if (clamp_hi) begin
            capture_val = 26'sd32767;
        end else if (clamp_lo) begin
            capture_val = -26'sd32768;
        end
    end
`else
    always_comb begin
        capture_val = mac_acc;
    end
`endif

    // Next-state and output decode; abort overrides every non-IDLE transition.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_a_d  = addr_a_q;
        addr_b_d  = addr_b_q;
        result_d  = result_q;
        aborted_d = 1'b0;
`ifdef MAC_SEQ_SAT_EN
        sat_d     = sat_q;
`endif
        rd_en     = 1'b0;
        mac_en    = 1'b0;
        mac_clr   = 1'b0;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
`ifdef MAC_SEQ_SAT_EN
                    sat_d = 1'b0;
`endif
                    if (len != '0) begin
                        cnt_d    = len - LEN_W'(1);
                        addr_a_d = base_a;
                        addr_b_d = base_b;
                        state_d  = CLEAR;
                    end else begin
                        result_d = '0;
                        state_d  = DONE;
                    end
                end
            end
            CLEAR: begin
                mac_clr  = 1'b1;
                rd_en    = 1'b1;
                addr_a_d = addr_a_q + ADDR_W'(1);
                addr_b_d = addr_b_q + ADDR_W'(1);
                state_d  = (cnt_q == '0) ? DRAIN : RUN;
            end
            RUN: begin
                rd_en    = 1'b1;
                mac_en   = 1'b1;
                addr_a_d = addr_a_q + ADDR_W'(1);
                addr_b_d = addr_b_q + ADDR_W'(1);
                cnt_d    = cnt_q - LEN_W'(1);
                if (cnt_q == LEN_W'(1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                mac_en  = 1'b1;
                state_d = CAPTURE;
            end
            CAPTURE: begin
                result_d = capture_val;
`ifdef MAC_SEQ_SAT_EN
                sat_d    = clamp_hi | clamp_lo;
`endif
                state_d  = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d   = IDLE;
            aborted_d = 1'b1;
            result_d  = result_q;
`ifdef MAC_SEQ_SAT_EN
            sat_d     = sat_q;
`endif
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_a_q  <= '0;
            addr_b_q  <= '0;
            result_q  <= '0;
            aborted_q <= 1'b0;
`ifdef MAC_SEQ_SAT_EN
            sat_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_a_q  <= addr_a_d;
            addr_b_q  <= addr_b_d;
            result_q  <= result_d;
            aborted_q <= aborted_d;
`ifdef MAC_SEQ_SAT_EN
            sat_q     <= sat_d;
`endif
        end
    end

    // Operands pass straight from memory to the MAC only while it accumulates.
    always_comb begin
        mac_a = mac_en ? a_data : 8'sd0;
        mac_b = mac_en ? b_data : 8'sd0;
    end

    assign busy    = (state_q != IDLE);
    assign aborted = aborted_q;
    assign addr_a  = addr_a_q;
    assign addr_b  = addr_b_q;
    assign result  = result_q;
`ifdef MAC_SEQ_SAT_EN
    assign sat     = sat_q;
`endif

endmodule

// File: tb/tb_mac_seq.sv
// Directed bench for mac_seq with a behavioural operand memory and MAC.
module tb_mac_seq;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [7:0]         len = '0;
    logic [7:0]         base_a = '0;
    logic [7:0]         base_b = '0;
    logic               abort = 1'b0;
    logic               rd_en;
    logic [7:0]         addr_a, addr_b;
    logic signed [7:0]  a_data = '0;
    logic signed [7:0]  b_data = '0;
    logic signed [7:0]  mac_a, mac_b;
    logic               mac_en, mac_clr;
    logic signed [25:0] mac_acc = '0;
    logic               busy, done, aborted;
    logic signed [25:0] result;
`ifdef MAC_SEQ_SAT_EN
    logic               sat;
`endif

    mac_seq #(.LEN_W(8), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .base_a(base_a), .base_b(base_b), .abort(abort),
        .rd_en(rd_en), .addr_a(addr_a), .addr_b(addr_b),
        .a_data(a_data), .b_data(b_data),
        .mac_a(mac_a), .mac_b(mac_b), .mac_en(mac_en), .mac_clr(mac_clr),
        .mac_acc(mac_acc), .busy(busy), .done(done), .aborted(aborted),
`ifdef MAC_SEQ_SAT_EN
        .sat(sat),
`endif
        .result(result)
    );

    always #5 clk = ~clk;

    logic signed [7:0] mem_a [256];
    logic signed [7:0] mem_b [256];

    // Operand memory: one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en) begin
            a_data <= mem_a[addr_a];
            b_data <= mem_b[addr_b];
        end
    end

    // Registered MAC unit.
    always @(posedge clk) begin
        if (rst || mac_clr) mac_acc <= '0;
        else if (mac_en)    mac_acc <= mac_acc + 26'(mac_a * mac_b);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int t_start, t_done, first_en, last_en;
    int n_done = 0, n_abt = 0, n_en = 0, n_clr = 0, n_rd = 0;
    logic prev_en = 1'b0;
    int addr_log [$];

    // Event monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (start && !busy) t_start = cyc;
        if (done) begin t_done = cyc; n_done++; end
        if (aborted) n_abt++;
        if (mac_en) begin
            n_en++;
            if (!prev_en) first_en = cyc;
            last_en = cyc;
        end
        prev_en = mac_en;
        if (mac_clr) n_clr++;
        if (rd_en) begin n_rd++; addr_log.push_back(int'(addr_a)); end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic issue_start(input logic [7:0] l, input logic [7:0] ba, input logic [7:0] bb);
        @(posedge clk); #1;
        start = 1'b1; len = l; base_a = ba; base_b = bb;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) begin seen = 1; break; end
        end
        #1;
        if (!seen) chk({tag, "_timeout"}, 0, 1);
    endtask

    int d0, e0, c0, r0, a0, l0;

    task automatic snap();
        d0 = n_done; e0 = n_en; c0 = n_clr; r0 = n_rd; a0 = n_abt; l0 = addr_log.size();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
        mem_a[0] = 8'sd2;  mem_a[1] = 8'sd2;  mem_a[2] = -8'sd3;
        mem_b[0] = 8'sd5;  mem_b[1] = -8'sd5; mem_b[2] = 8'sd8;
        for (int i = 16; i < 19; i++) begin mem_a[i] = 8'sd127; mem_b[i] = 8'sd127; end
        mem_a[254] = 8'sd1; mem_a[255] = 8'sd2;
        for (int i = 10; i < 14; i++) mem_b[i] = 8'sd1;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_outs", int'({rd_en, mac_en, mac_clr, done, aborted}), 0);
        chk("rst_result", int'(result), 0);

        // Basic dot product: 10 - 10 - 24 = -24
        snap();
        issue_start(8'd3, 8'd0, 8'd0);
        wait_done("t1");
        chk("t1_result", int'(result), -24);
        chk("t1_latency", t_done - t_start, 6);
        chk("t1_en_first", first_en - t_start, 2);
        chk("t1_en_last", last_en - t_start, 4);
        chk("t1_en_count", n_en - e0, 3);
        chk("t1_clr_count", n_clr - c0, 1);
        chk("t1_rd_count", n_rd - r0, 3);

        // Abort at T+3, restart attempt at T+2 ignored, result preserved
        snap();
        @(posedge clk); #1;
        start = 1'b1; len = 8'd5; base_a = 8'd0; base_b = 8'd0;
        @(posedge clk); #1;            // cycle T+1
        start = 1'b0;
        @(posedge clk); #1;            // cycle T+2
        start = 1'b1; len = 8'd1;
        @(posedge clk); #1;            // cycle T+3
        start = 1'b0; abort = 1'b1;
        @(posedge clk); #1;            // cycle T+4
        abort = 1'b0;
        @(negedge clk);
        chk("abt_pulse", int'(aborted), 1);
        chk("abt_busy", int'(busy), 0);
        repeat (10) @(negedge clk);
        chk("abt_no_done", n_done - d0, 0);
        chk("abt_pulse_count", n_abt - a0, 1);
        chk("abt_result", int'(result), -24);

        // Large products
        snap();
        issue_start(8'd3, 8'd16, 8'd16);
        wait_done("t2");
`ifdef MAC_SEQ_SAT_EN
        chk("t2_result_sat", int'(result), 32767);
        chk("t2_sat_flag", int'(sat), 1);
`else
        chk("t2_result", int'(result), 48387);
`endif

        // len == 0
        snap();
        issue_start(8'd0, 8'd0, 8'd0);
        wait_done("z");
        chk("z_latency", t_done - t_start, 1);
        chk("z_result", int'(result), 0);
        chk("z_no_strobes", (n_rd - r0) + (n_en - e0) + (n_clr - c0), 0);
`ifdef MAC_SEQ_SAT_EN
        chk("z_sat_cleared", int'(sat), 0);
`endif

        // Address wrap: 1+2+2+2 = 7
        snap();
        issue_start(8'd4, 8'd254, 8'd10);
        wait_done("w");
        chk("w_rd_count", addr_log.size() - l0, 4);
        if (addr_log.size() - l0 == 4) begin
            chk("w_addr0", addr_log[l0],   254);
            chk("w_addr1", addr_log[l0+1], 255);
            chk("w_addr2", addr_log[l0+2], 0);
            chk("w_addr3", addr_log[l0+3], 1);
        end
        chk("w_result", int'(result), 7);
        chk("w_latency", t_done - t_start, 7);

        // Reset mid-operation at T+3
        snap();
        issue_start(8'd5, 8'd0, 8'd0);  // now in cycle T+1
        @(posedge clk); #1;             // T+2
        @(posedge clk); #1;             // T+3
        rst = 1'b1;
        @(posedge clk); #1;             // T+4
        rst = 1'b0;
        @(negedge clk);
        chk("mr_busy", int'(busy), 0);
        chk("mr_strobes", int'({rd_en, mac_en, mac_clr, done, aborted}), 0);
        chk("mr_ops", int'({mac_a, mac_b}), 0);
        chk("mr_addr", int'({addr_a, addr_b}), 0);
        chk("mr_result", int'(result), 0);
        repeat (8) @(negedge clk);
        chk("mr_no_pulses", (n_done - d0) + (n_abt - a0), 0);

        // Fresh run after reset
        issue_start(8'd3, 8'd0, 8'd0);
        wait_done("t3");
        chk("t3_result", int'(result), -24);
        chk("t3_latency", t_done - t_start, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
